// File: rtl/dcfeb_fiber_pkg.sv
// Purpose: shared constants, link-state encoding and word classes for the DCFEB fiber frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcfeb_fiber_pkg;

    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_ISK  = 4'b0101;
    localparam logic [15:0] SEP       = 16'h50BC;
    localparam logic [15:0] SEP_LT    = 16'h50FC;
    localparam logic [3:0]  HDR_ISK   = 4'b0001;
    localparam logic [3:0]  PAY_ISK   = 4'b0000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } link_state_t;

    typedef enum logic [2:0] {
        WC_BAD   = 3'd0,
        WC_IDLE  = 3'd1,
        WC_HDR   = 3'd2,
        WC_PAY   = 3'd3,
        WC_OTHER = 3'd4
    } word_class_t;

endpackage

// File: rtl/dcfeb_fiber_rx_frame_if.sv
// Purpose: bundles the decoded receive word stream and the recovered frame/link outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the receive stream is a free-running one-word-per-clock feed.
// Ports: master = stimulus/consumer side (drives RX_*, ERR_CLR); slave = frame decoder.
interface dcfeb_fiber_rx_frame_if;

    logic [31:0] RX_DATA;
    logic [3:0]  RX_ISK;
    logic [3:0]  RX_DISPERR;
    logic [3:0]  RX_NOTINTABLE;
    logic        ERR_CLR;

    logic [7:0]  G1C;
    logic [7:0]  G2C;
    logic [7:0]  G3C;
    logic [7:0]  G4C;
    logic [7:0]  G5C;
    logic [7:0]  G6C;
    logic        DATA_VALID;
    logic        LTNCY_MARK;
    logic        MARK_ERR;
    logic        LINK_LOCKED;
    logic [1:0]  LINK_STATE;
    logic [15:0] FRAME_ERR_CNT;

    modport master (
        output RX_DATA, RX_ISK, RX_DISPERR, RX_NOTINTABLE, ERR_CLR,
        input  G1C, G2C, G3C, G4C, G5C, G6C, DATA_VALID, LTNCY_MARK, MARK_ERR,
        input  LINK_LOCKED, LINK_STATE, FRAME_ERR_CNT
    );

    modport slave (
        input  RX_DATA, RX_ISK, RX_DISPERR, RX_NOTINTABLE, ERR_CLR,
        output G1C, G2C, G3C, G4C, G5C, G6C, DATA_VALID, LTNCY_MARK, MARK_ERR,
        output LINK_LOCKED, LINK_STATE, FRAME_ERR_CNT
    );

endinterface

// File: rtl/dcfeb_rx_word_class.sv
// Purpose: classifies one decoded receive word (BAD/IDLE/HDR/PAY/OTHER) and flags latency-marker headers.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: rx_data/rx_isk/rx_disperr/rx_notintable in; wclass, is_mark out.
module dcfeb_rx_word_class
    import dcfeb_fiber_pkg::*;
(
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_isk,
    input  logic [3:0]  rx_disperr,
    input  logic [3:0]  rx_notintable,
    output word_class_t wclass,
    output logic        is_mark
);

    always_comb begin
        wclass  = WC_OTHER;
        is_mark = 1'b0;
        // Any code-level error poisons the word regardless of its content.
        if ((|rx_disperr) || (|rx_notintable)) begin
            wclass = WC_BAD;
        end else if (rx_data == IDLE_WORD && rx_isk == IDLE_ISK) begin
            wclass = WC_IDLE;
        end else if (rx_isk == HDR_ISK && (rx_data[15:0] == SEP || rx_data[15:0] == SEP_LT)) begin
            wclass  = WC_HDR;
            is_mark = (rx_data[15:0] == SEP_LT);
        end else if (rx_isk == PAY_ISK) begin
            wclass = WC_PAY;
        end
    end

endmodule

// File: rtl/dcfeb_fiber_rx_frame.sv
// Purpose: aligns to the HDR+PAY comparator frame, tracks link lock, recovers G1C..G6C and the latency marker.
// Latency: outputs update on the clock edge that samples the PAY word (1 edge).
// Backpressure: none; every input word is consumed, the flywheel phase never stalls.
// Ports: TRG_CLK80, TRG_RST (sync, active-high), bus = dcfeb_fiber_rx_frame_if.slave.
module dcfeb_fiber_rx_frame
    import dcfeb_fiber_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERR  = 4,
    parameter int MARK_PERIOD = 128
) (
    input logic                    TRG_CLK80,
    input logic                    TRG_RST,
    dcfeb_fiber_rx_frame_if.slave  bus
);

    localparam logic [7:0] GOOD_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] BAD_LAST  = 4'(UNLOCK_ERR - 1);
    localparam logic [6:0] MARK_LAST = 7'(MARK_PERIOD - 1);

    word_class_t wclass;
    logic        is_mark;

    dcfeb_rx_word_class u_class (
        .rx_data       (bus.RX_DATA),
        .rx_isk        (bus.RX_ISK),
        .rx_disperr    (bus.RX_DISPERR),
        .rx_notintable (bus.RX_NOTINTABLE),
        .wclass        (wclass),
        .is_mark       (is_mark)
    );

    link_state_t state;
    logic        pay_slot;   // 1 = this cycle is the payload slot of the frame
    logic        hdr_ok;     // header slot held a valid HDR word
    logic        hdr_mark;   // header separator was the latency marker
    logic [15:0] hdr_pay;
    logic [7:0]  good_cnt;
    logic [3:0]  bad_cnt;
    logic [6:0]  frame_cnt;
    logic        mark_ref;   // a reference marker has been seen since entering LOCKED

    wire frame_good = hdr_ok && (wclass == WC_PAY);

    assign bus.LINK_STATE = state;

    always_ff @(posedge TRG_CLK80) begin
        if (TRG_RST) begin
            state             <= HUNT;
            pay_slot          <= 1'b0;
            hdr_ok            <= 1'b0;
            hdr_mark          <= 1'b0;
            hdr_pay           <= '0;
            good_cnt          <= '0;
            bad_cnt           <= '0;
            frame_cnt         <= '0;
            mark_ref          <= 1'b0;
            bus.G1C           <= '0;
            bus.G2C           <= '0;
            bus.G3C           <= '0;
            bus.G4C           <= '0;
            bus.G5C           <= '0;
            bus.G6C           <= '0;
            bus.DATA_VALID    <= 1'b0;
            bus.LTNCY_MARK    <= 1'b0;
            bus.MARK_ERR      <= 1'b0;
            bus.LINK_LOCKED   <= 1'b0;
            bus.FRAME_ERR_CNT <= '0;
        end else begin
            bus.DATA_VALID <= 1'b0;
            bus.LTNCY_MARK <= 1'b0;
            bus.MARK_ERR   <= 1'b0;
            if (bus.ERR_CLR) begin
                bus.FRAME_ERR_CNT <= '0;
            end

            case (state)
                HUNT: begin
                    mark_ref <= 1'b0;
                    if (wclass == WC_HDR) begin
                        pay_slot <= 1'b1;
                        hdr_ok   <= 1'b1;
                        hdr_mark <= is_mark;
                        hdr_pay  <= bus.RX_DATA[31:16];
                        good_cnt <= '0;
                        state    <= SYNC;
                    end
                end

                SYNC: begin
                    pay_slot <= ~pay_slot;
                    if (wclass == WC_IDLE) begin
                        state <= HUNT;
                    end else if (!pay_slot) begin
                        hdr_ok   <= (wclass == WC_HDR);
                        hdr_mark <= is_mark;
                        hdr_pay  <= bus.RX_DATA[31:16];
                    end else if (frame_good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state           <= LOCKED;
                            bus.LINK_LOCKED <= 1'b1;
                            bad_cnt         <= '0;
                            frame_cnt       <= '0;
                            mark_ref        <= 1'b0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end else begin
                        state <= HUNT;
                    end
                end

                LOCKED: begin
                    pay_slot <= ~pay_slot;
                    if (wclass == WC_IDLE) begin
                        // Far end is in reset: drop lock without charging an error.
                        state           <= HUNT;
                        bus.LINK_LOCKED <= 1'b0;
                    end else if (!pay_slot) begin
                        hdr_ok   <= (wclass == WC_HDR);
                        hdr_mark <= is_mark;
                        hdr_pay  <= bus.RX_DATA[31:16];
                    end else begin
                        frame_cnt <= frame_cnt + 7'd1;
                        if (frame_good) begin
                            bad_cnt        <= '0;
                            bus.G1C        <= hdr_pay[7:0];
                            bus.G2C        <= hdr_pay[15:8];
                            bus.G3C        <= bus.RX_DATA[7:0];
                            bus.G4C        <= bus.RX_DATA[15:8];
                            bus.G5C        <= bus.RX_DATA[23:16];
                            bus.G6C        <= bus.RX_DATA[31:24];
                            bus.DATA_VALID <= 1'b1;
                            if (hdr_mark) begin
                                bus.LTNCY_MARK <= 1'b1;
                                bus.MARK_ERR   <= mark_ref && (frame_cnt != MARK_LAST);
                                frame_cnt      <= '0;
                                mark_ref       <= 1'b1;
                            end
                        end else begin
                            // Clear has priority over a same-cycle increment.
                            if (!bus.ERR_CLR && bus.FRAME_ERR_CNT != 16'hFFFF) begin
                                bus.FRAME_ERR_CNT <= bus.FRAME_ERR_CNT + 16'd1;
                            end
                            if (bad_cnt == BAD_LAST) begin
                                state           <= HUNT;
                                bus.LINK_LOCKED <= 1'b0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end
                    end
                end

                default: begin
                    state           <= HUNT;
                    bus.LINK_LOCKED <= 1'b0;
                end
            endcase
        end
    end

endmodule
